// File: rtl/alu_exec_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_stage_pkg
// Description : Shared ALU operation codes plus the ALUOp / funct constants
//               used by the control decoder that feeds the execute stage.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_exec_stage_pkg;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_XOR = 4'b0011,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_NOR = 4'b1100
    } alu_op_e;

    localparam logic [1:0] c_ALUOP_MEM    = 2'b00;
    localparam logic [1:0] c_ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] c_ALUOP_RTYPE  = 2'b10;

    localparam logic [5:0] c_ADD_FUNCT = 6'h20;
    localparam logic [5:0] c_SUB_FUNCT = 6'h22;
    localparam logic [5:0] c_AND_FUNCT = 6'h24;
    localparam logic [5:0] c_OR_FUNCT  = 6'h25;
    localparam logic [5:0] c_XOR_FUNCT = 6'h26;
    localparam logic [5:0] c_NOR_FUNCT = 6'h27;
    localparam logic [5:0] c_SLT_FUNCT = 6'h2a;

endpackage
`default_nettype wire

// File: rtl/alu_exec_stage_core.sv
`default_nettype none
// ============================================================================
// Module      : alu_core
// Description : Purely combinational 32-bit ALU with zero/overflow/illegal.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_core
    import alu_exec_stage_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [3:0]        alu_control,
    input  logic [DATA_W-1:0] operand_a,
    input  logic [DATA_W-1:0] operand_b,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              overflow,
    output logic              illegal
);

    logic [DATA_W-1:0] w_sum;
    logic [DATA_W-1:0] w_diff;
    logic              w_lt;

    assign w_sum  = operand_a + operand_b;
    assign w_diff = operand_a - operand_b;
    assign w_lt   = $signed(operand_a) < $signed(operand_b);

    always_comb begin
        result   = '0;
        overflow = 1'b0;
        illegal  = 1'b0;
        case (alu_control)
            ALU_AND: result = operand_a & operand_b;
            ALU_OR:  result = operand_a | operand_b;
            ALU_XOR: result = operand_a ^ operand_b;
            ALU_NOR: result = ~(operand_a | operand_b);
            ALU_ADD: begin
                result   = w_sum;
                overflow = (operand_a[DATA_W-1] == operand_b[DATA_W-1]) &&
                           (w_sum[DATA_W-1] != operand_a[DATA_W-1]);
            end
            ALU_SUB: begin
                result   = w_diff;
                overflow = (operand_a[DATA_W-1] != operand_b[DATA_W-1]) &&
                           (w_diff[DATA_W-1] != operand_a[DATA_W-1]);
            end
            ALU_SLT: result = {{(DATA_W-1){1'b0}}, w_lt};
            default: illegal = 1'b1;
        endcase
    end

    assign zero = (result == '0);

endmodule
`default_nettype wire

// File: rtl/alu_exec_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_stage
// Description : Execute stage: ALU result into an EX/MEM register (M) with a
//               one-entry skid register (S) behind valid/ready handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_exec_stage
    import alu_exec_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        alu_control,
    input  logic [DATA_W-1:0] operand_a,
    input  logic [DATA_W-1:0] operand_b,
    input  logic [REG_W-1:0]  rd_in,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] alu_result,
    output logic              zero,
    output logic              overflow,
    output logic [REG_W-1:0]  rd_out,
    output logic              illegal_op
);

    logic [DATA_W-1:0] w_result;
    logic              w_zero;
    logic              w_overflow;
    logic              w_illegal;
    logic              w_accept;
    logic              w_drain;

    logic              r_m_valid;
    logic [DATA_W-1:0] r_m_result;
    logic              r_m_zero;
    logic              r_m_overflow;
    logic              r_m_illegal;
    logic [REG_W-1:0]  r_m_rd;

    logic              r_s_valid;
    logic [DATA_W-1:0] r_s_result;
    logic              r_s_zero;
    logic              r_s_overflow;
    logic              r_s_illegal;
    logic [REG_W-1:0]  r_s_rd;

    alu_core #(
        .DATA_W (DATA_W)
    ) u_alu_core (
        .alu_control (alu_control),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .result      (w_result),
        .zero        (w_zero),
        .overflow    (w_overflow),
        .illegal     (w_illegal)
    );

    // Ready depends only on the registered skid state, so upstream never
    // sees a combinational path from out_ready.
    assign in_ready = ~reset & ~r_s_valid;
    assign w_accept = in_valid & in_ready & ~flush;
    assign w_drain  = r_m_valid & out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_m_valid    <= 1'b0;
            r_m_result   <= '0;
            r_m_zero     <= 1'b1;
            r_m_overflow <= 1'b0;
            r_m_illegal  <= 1'b0;
            r_m_rd       <= '0;
            r_s_valid    <= 1'b0;
            r_s_result   <= '0;
            r_s_zero     <= 1'b1;
            r_s_overflow <= 1'b0;
            r_s_illegal  <= 1'b0;
            r_s_rd       <= '0;
        end else if (flush) begin
            r_m_valid <= 1'b0;
            r_s_valid <= 1'b0;
        end else if (w_drain && r_s_valid) begin
            // S is full so in_ready is low: no accept can coincide here.
            r_m_valid    <= 1'b1;
            r_m_result   <= r_s_result;
            r_m_zero     <= r_s_zero;
            r_m_overflow <= r_s_overflow;
            r_m_illegal  <= r_s_illegal;
            r_m_rd       <= r_s_rd;
            r_s_valid    <= 1'b0;
        end else if (w_accept && (!r_m_valid || w_drain)) begin
            r_m_valid    <= 1'b1;
            r_m_result   <= w_result;
            r_m_zero     <= w_zero;
            r_m_overflow <= w_overflow;
            r_m_illegal  <= w_illegal;
            r_m_rd       <= rd_in;
        end else if (w_accept) begin
            r_s_valid    <= 1'b1;
            r_s_result   <= w_result;
            r_s_zero     <= w_zero;
            r_s_overflow <= w_overflow;
            r_s_illegal  <= w_illegal;
            r_s_rd       <= rd_in;
        end else if (w_drain) begin
            r_m_valid <= 1'b0;
        end
    end

    assign out_valid  = r_m_valid;
    assign alu_result = r_m_result;
    assign zero       = r_m_zero;
    assign overflow   = r_m_overflow;
    assign rd_out     = r_m_rd;
    assign illegal_op = r_m_illegal;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_exec_stage
// Description : Self-checking bench: directed and random ops against an
//               arithmetic reference model and a FIFO scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_exec_stage;

    typedef struct {
        logic [31:0] result;
        logic        zero;
        logic        ovf;
        logic        ill;
        logic [4:0]  rd;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_control;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [4:0]  rd_in;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_result;
    logic        zero;
    logic        overflow;
    logic [4:0]  rd_out;
    logic        illegal_op;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t q[$];

    alu_exec_stage #(
        .DATA_W (32),
        .REG_W  (5)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .alu_control (alu_control),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .rd_in       (rd_in),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .alu_result  (alu_result),
        .zero        (zero),
        .overflow    (overflow),
        .rd_out      (rd_out),
        .illegal_op  (illegal_op)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic exp_t ref_op(input logic [3:0] c, input logic [31:0] a,
                                    input logic [31:0] b, input logic [4:0] rd);
        exp_t   e;
        longint sa;
        longint sb;
        longint s;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e.result = 32'd0;
        e.ovf    = 1'b0;
        e.ill    = 1'b0;
        e.rd     = rd;
        case (c)
            4'b0000: e.result = a & b;
            4'b0001: e.result = a | b;
            4'b0011: e.result = a ^ b;
            4'b1100: e.result = ~(a | b);
            4'b0010, 4'b0110: begin
                s = (c == 4'b0010) ? sa + sb : sa - sb;
                e.result = s[31:0];
                e.ovf    = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'b0111: e.result = (sa < sb) ? 32'd1 : 32'd0;
            default: e.ill = 1'b1;
        endcase
        e.zero = (e.result == 32'd0);
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, check presented state against the model,
    // advance the model for the coming edge, then take the edge.
    task automatic step(input logic v, input logic [3:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic ordy, input logic fl, input logic rst);
        logic exp_rdy;
        reset = rst; in_valid = v; alu_control = c; operand_a = a;
        operand_b = b; rd_in = rd; out_ready = ordy; flush = fl;
        #1;
        exp_rdy = !rst && (q.size() < 2);
        check("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
        check("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
        if (q.size() > 0) begin
            check("alu_result", alu_result, q[0].result);
            check("zero", {31'd0, zero}, {31'd0, q[0].zero});
            check("overflow", {31'd0, overflow}, {31'd0, q[0].ovf});
            check("illegal_op", {31'd0, illegal_op}, {31'd0, q[0].ill});
            check("rd_out", {27'd0, rd_out}, {27'd0, q[0].rd});
        end
        if (rst || fl) begin
            q.delete();
        end else begin
            if (ordy && q.size() > 0) void'(q.pop_front());
            if (v && exp_rdy) q.push_back(ref_op(c, a, b, rd));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 4'b0000, 32'd0, 32'd0, 5'd0, ordy, 1'b0, 1'b0);
    endtask

    logic [3:0] codes [8];
    logic [31:0] edge_v [6];

    initial begin
        codes  = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0110, 4'b0111, 4'b1100, 4'b1010};
        edge_v = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h0000000A};
        reset = 1'b1; in_valid = 1'b0; alu_control = '0; operand_a = '0;
        operand_b = '0; rd_in = '0; flush = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;

        // Reset state
        step(1'b0, 4'b0, 32'd0, 32'd0, 5'd0, 1'b1, 1'b0, 1'b1);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result", alu_result, 32'd0);
        check("rst_zero", {31'd0, zero}, 32'd1);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        check("rst_rd", {27'd0, rd_out}, 32'd0);
        check("rst_ill", {31'd0, illegal_op}, 32'd0);
        check("rst_ready", {31'd0, in_ready}, 32'd0);

        // Overflowing add, one-cycle latency
        step(1'b1, 4'b0010, 32'h7FFFFFFF, 32'd1, 5'd5, 1'b1, 1'b0, 1'b0);
        check("add_valid", {31'd0, out_valid}, 32'd1);
        check("add_result", alu_result, 32'h80000000);
        check("add_ovf", {31'd0, overflow}, 32'd1);
        check("add_rd", {27'd0, rd_out}, 32'd5);
        idle(1'b1);

        // Back-to-back sub / slt / nor
        step(1'b1, 4'b0110, 32'd10, 32'd10, 5'd1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 4'b0111, 32'hFFFFFFFF, 32'd1, 5'd2, 1'b1, 1'b0, 1'b0);
        step(1'b1, 4'b1100, 32'd0, 32'd0, 5'd3, 1'b1, 1'b0, 1'b0);
        check("nor_pre_result", alu_result, 32'hFFFFFFFF);
        idle(1'b1);

        // Stall: fill M and S, third op held upstream until space opens
        step(1'b1, 4'b0010, 32'd0, 32'd1, 5'd1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'b0010, 32'd0, 32'd2, 5'd2, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'b0010, 32'd0, 32'd3, 5'd3, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'b0010, 32'd0, 32'd3, 5'd3, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'b0010, 32'd0, 32'd3, 5'd3, 1'b1, 1'b0, 1'b0);
        step(1'b1, 4'b0010, 32'd0, 32'd3, 5'd3, 1'b1, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // Illegal code
        step(1'b1, 4'b1010, 32'h1234, 32'h5678, 5'd9, 1'b1, 1'b0, 1'b0);
        check("ill_flag", {31'd0, illegal_op}, 32'd1);
        check("ill_result", alu_result, 32'd0);
        idle(1'b1);

        // Flush with M and S full plus a new offer
        step(1'b1, 4'b0001, 32'hF0, 32'h0F, 5'd4, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'b0011, 32'hFF, 32'h0F, 5'd6, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'b0010, 32'd7, 32'd7, 5'd7, 1'b1, 1'b1, 1'b0);
        check("flush_valid", {31'd0, out_valid}, 32'd0);
        check("flush_ready", {31'd0, in_ready}, 32'd1);
        idle(1'b1);
        idle(1'b1);

        // Reset mid-stall with S full
        step(1'b1, 4'b0010, 32'd1, 32'd1, 5'd8, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'b0010, 32'd2, 32'd2, 5'd9, 1'b0, 1'b0, 1'b0);
        step(1'b0, 4'b0000, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        check("mrst_valid", {31'd0, out_valid}, 32'd0);
        check("mrst_result", alu_result, 32'd0);
        check("mrst_zero", {31'd0, zero}, 32'd1);
        step(1'b0, 4'b0000, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        idle(1'b1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 5)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 5)] : $urandom;
            step($urandom_range(0, 3) != 0, codes[$urandom_range(0, 7)], a, b,
                 5'($urandom_range(0, 31)), $urandom_range(0, 2) != 0,
                 $urandom_range(0, 24) == 0, $urandom_range(0, 59) == 0);
        end
        for (int i = 0; i < 3; i++) idle(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
